// File: rtl/vend_controller.sv
// Vending sequencer: coin credit accumulation, price check, dispenser handshake and
// greedy change payout from tracked per-denomination coin inventory.
module vend_controller #(
  parameter int unsigned BASE_PRICE   = 25,
  parameter int unsigned STEP_PRICE   = 5,
  parameter int unsigned NICKEL_INIT  = 20,
  parameter int unsigned DIME_INIT    = 10,
  parameter int unsigned QUARTER_INIT = 8,
  parameter int unsigned DOLLAR_INIT  = 4
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_coin_valid,
  input  logic [1:0] i_coin_value,
  input  logic       i_sel_valid,
  input  logic [2:0] i_selection,
  input  logic       i_refund_req,
  output logic       o_vend_req,
  output logic [2:0] o_item_id,
  input  logic       i_vend_ack,
  output logic       o_coin_out_valid,
  output logic [1:0] o_coin_out_type,
  input  logic       i_coin_out_ready,
  output logic [7:0] o_credit,
  output logic       o_busy,
  output logic       o_coin_reject,
  output logic       o_err_insufficient,
  output logic       o_change_short
);

  typedef enum logic [1:0] {StIdle, StVend, StChange} state_e;

  state_e     r_state;
  logic [7:0] r_credit;
  logic       r_vend_req;
  logic [2:0] r_item_id;
  logic       r_coin_out_valid;
  logic [1:0] r_coin_out_type;
  logic       r_busy;
  logic       r_coin_reject;
  logic       r_err_insufficient;
  logic       r_change_short;
  logic [4:0] r_inv [4];

  logic [7:0] w_coin_in;
  logic [8:0] w_sum;
  logic [7:0] w_price;
  logic [7:0] w_out_cents;
  logic       w_pick_ok;
  logic [1:0] w_pick_type;

  function automatic logic [7:0] coin_cents(input logic [1:0] t);
    case (t)
      2'd0:    return 8'd5;
      2'd1:    return 8'd10;
      2'd2:    return 8'd25;
      default: return 8'd100;
    endcase
  endfunction

  always_comb begin
    w_coin_in   = coin_cents(i_coin_value);
    w_sum       = {1'b0, r_credit} + {1'b0, w_coin_in};
    w_price     = 8'(BASE_PRICE + STEP_PRICE * 32'(i_selection));
    w_out_cents = coin_cents(r_coin_out_type);
    // Greedy: largest coin that fits the remaining credit and is in stock.
    w_pick_ok   = 1'b1;
    w_pick_type = 2'd0;
    if (r_credit >= 8'd100 && r_inv[3] != 5'd0) begin
      w_pick_type = 2'd3;
    end else if (r_credit >= 8'd25 && r_inv[2] != 5'd0) begin
      w_pick_type = 2'd2;
    end else if (r_credit >= 8'd10 && r_inv[1] != 5'd0) begin
      w_pick_type = 2'd1;
    end else if (r_credit >= 8'd5 && r_inv[0] != 5'd0) begin
      w_pick_type = 2'd0;
    end else begin
      w_pick_ok = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state            <= StIdle;
      r_credit           <= 8'd0;
      r_vend_req         <= 1'b0;
      r_item_id          <= 3'd0;
      r_coin_out_valid   <= 1'b0;
      r_coin_out_type    <= 2'd0;
      r_busy             <= 1'b0;
      r_coin_reject      <= 1'b0;
      r_err_insufficient <= 1'b0;
      r_change_short     <= 1'b0;
      r_inv[0]           <= 5'(NICKEL_INIT);
      r_inv[1]           <= 5'(DIME_INIT);
      r_inv[2]           <= 5'(QUARTER_INIT);
      r_inv[3]           <= 5'(DOLLAR_INIT);
    end else begin
      r_coin_reject      <= 1'b0;
      r_err_insufficient <= 1'b0;
      r_change_short     <= 1'b0;
      if (i_coin_valid && r_state != StIdle) r_coin_reject <= 1'b1;

      unique case (r_state)
        StIdle: begin
          if (i_coin_valid) begin
            if (!w_sum[8]) begin
              r_credit <= w_sum[7:0];
              if (r_inv[i_coin_value] != 5'd31) r_inv[i_coin_value] <= r_inv[i_coin_value] + 5'd1;
            end else begin
              r_coin_reject <= 1'b1;
            end
          end else if (i_sel_valid) begin
            if (r_credit >= w_price) begin
              r_credit   <= r_credit - w_price;
              r_item_id  <= i_selection;
              r_vend_req <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= StVend;
            end else begin
              r_err_insufficient <= 1'b1;
            end
          end else if (i_refund_req && r_credit != 8'd0) begin
            r_busy  <= 1'b1;
            r_state <= StChange;
          end
        end
        StVend: begin
          if (i_vend_ack) begin
            r_vend_req <= 1'b0;
            if (r_credit != 8'd0) begin
              r_state <= StChange;
            end else begin
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end
          end
        end
        StChange: begin
          if (r_coin_out_valid) begin
            if (i_coin_out_ready) begin
              r_coin_out_valid <= 1'b0;
              r_credit         <= r_credit - w_out_cents;
              if (r_inv[r_coin_out_type] != 5'd0) begin
                r_inv[r_coin_out_type] <= r_inv[r_coin_out_type] - 5'd1;
              end
              if (r_credit == w_out_cents) begin
                r_busy  <= 1'b0;
                r_state <= StIdle;
              end
            end
          end else if (w_pick_ok) begin
            r_coin_out_valid <= 1'b1;
            r_coin_out_type  <= w_pick_type;
          end else begin
            // Remaining credit stays on account for a later retry or purchase.
            r_change_short <= 1'b1;
            r_busy         <= 1'b0;
            r_state        <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_vend_req         = r_vend_req;
  assign o_item_id          = r_item_id;
  assign o_coin_out_valid   = r_coin_out_valid;
  assign o_coin_out_type    = r_coin_out_type;
  assign o_credit           = r_credit;
  assign o_busy             = r_busy;
  assign o_coin_reject      = r_coin_reject;
  assign o_err_insufficient = r_err_insufficient;
  assign o_change_short     = r_change_short;

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: three instances with different coin inventories
// share one stimulus stream; each scenario checks the instance it targets.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_value = 2'd0;
  logic       sel_valid = 1'b0;
  logic [2:0] selection = 3'd0;
  logic       refund_req = 1'b0;
  logic       vend_ack = 1'b0;
  logic       coin_out_ready = 1'b0;

  logic       vend_req [3];
  logic [2:0] item_id [3];
  logic       coin_out_valid [3];
  logic [1:0] coin_out_type [3];
  logic [7:0] credit [3];
  logic       busy [3];
  logic       coin_reject [3];
  logic       err_insufficient [3];
  logic       change_short [3];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  vend_controller u_dut0 (
    .i_clock(clk), .i_reset_n(rst_n), .i_coin_valid(coin_valid), .i_coin_value(coin_value),
    .i_sel_valid(sel_valid), .i_selection(selection), .i_refund_req(refund_req),
    .o_vend_req(vend_req[0]), .o_item_id(item_id[0]), .i_vend_ack(vend_ack),
    .o_coin_out_valid(coin_out_valid[0]), .o_coin_out_type(coin_out_type[0]),
    .i_coin_out_ready(coin_out_ready), .o_credit(credit[0]), .o_busy(busy[0]),
    .o_coin_reject(coin_reject[0]), .o_err_insufficient(err_insufficient[0]),
    .o_change_short(change_short[0])
  );

  vend_controller #(.QUARTER_INIT(0)) u_dut1 (
    .i_clock(clk), .i_reset_n(rst_n), .i_coin_valid(coin_valid), .i_coin_value(coin_value),
    .i_sel_valid(sel_valid), .i_selection(selection), .i_refund_req(refund_req),
    .o_vend_req(vend_req[1]), .o_item_id(item_id[1]), .i_vend_ack(vend_ack),
    .o_coin_out_valid(coin_out_valid[1]), .o_coin_out_type(coin_out_type[1]),
    .i_coin_out_ready(coin_out_ready), .o_credit(credit[1]), .o_busy(busy[1]),
    .o_coin_reject(coin_reject[1]), .o_err_insufficient(err_insufficient[1]),
    .o_change_short(change_short[1])
  );

  vend_controller #(.NICKEL_INIT(0), .DIME_INIT(0)) u_dut2 (
    .i_clock(clk), .i_reset_n(rst_n), .i_coin_valid(coin_valid), .i_coin_value(coin_value),
    .i_sel_valid(sel_valid), .i_selection(selection), .i_refund_req(refund_req),
    .o_vend_req(vend_req[2]), .o_item_id(item_id[2]), .i_vend_ack(vend_ack),
    .o_coin_out_valid(coin_out_valid[2]), .o_coin_out_type(coin_out_type[2]),
    .i_coin_out_ready(coin_out_ready), .o_credit(credit[2]), .o_busy(busy[2]),
    .o_coin_reject(coin_reject[2]), .o_err_insufficient(err_insufficient[2]),
    .o_change_short(change_short[2])
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Inputs change 1ns after the edge; outputs read then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic put_coin(input logic [1:0] v);
    coin_valid = 1'b1;
    coin_value = v;
    tick();
    coin_valid = 1'b0;
  endtask

  task automatic select(input logic [2:0] s);
    sel_valid = 1'b1;
    selection = s;
    tick();
    sel_valid = 1'b0;
  endtask

  task automatic refund();
    refund_req = 1'b1;
    tick();
    refund_req = 1'b0;
  endtask

  task automatic ack_vend();
    vend_ack = 1'b1;
    tick();
    vend_ack = 1'b0;
  endtask

  task automatic wait_coin(input int k, input string tag, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (coin_out_valid[k]) seen = 1'b1;
      else tick();
    end
    check({tag, "_seen"}, int'(seen), 1);
  endtask

  task automatic expect_coin(input int k, input int typ, input string tag);
    bit seen;
    wait_coin(k, tag, seen);
    if (seen) begin
      check({tag, "_type"}, int'(coin_out_type[k]), typ);
      coin_out_ready = 1'b1;
      tick();
      coin_out_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit seen;
    bit got_short;

    // Reset state
    do_reset();
    check("rst_credit", int'(credit[0]), 0);
    check("rst_busy", int'(busy[0]), 0);
    check("rst_vend_req", int'(vend_req[0]), 0);
    check("rst_coin_out_valid", int'(coin_out_valid[0]), 0);
    refund();
    check("refund_zero_ignored", int'(busy[0]), 0);

    // 25+25+10, select 3 (40): change 20 as dime, dime
    put_coin(2'd2);
    put_coin(2'd2);
    put_coin(2'd1);
    check("t1_credit60", int'(credit[0]), 60);
    select(3'd3);
    check("t1_vend_req", int'(vend_req[0]), 1);
    check("t1_item_id", int'(item_id[0]), 3);
    check("t1_credit20", int'(credit[0]), 20);
    check("t1_busy", int'(busy[0]), 1);
    tick();
    check("t1_vend_req_held", int'(vend_req[0]), 1);
    ack_vend();
    check("t1_vend_req_drop", int'(vend_req[0]), 0);
    expect_coin(0, 1, "t1_coin1");
    expect_coin(0, 1, "t1_coin2");
    check("t1_credit0", int'(credit[0]), 0);
    check("t1_idle", int'(busy[0]), 0);
    check("t1_valid_low", int'(coin_out_valid[0]), 0);

    // Insufficient credit; coin beats a coinciding selection
    do_reset();
    put_coin(2'd0);
    select(3'd6);
    check("t2_err", int'(err_insufficient[0]), 1);
    check("t2_credit", int'(credit[0]), 5);
    check("t2_vend_req", int'(vend_req[0]), 0);
    check("t2_busy", int'(busy[0]), 0);
    tick();
    check("t2_err_pulse", int'(err_insufficient[0]), 0);
    coin_valid = 1'b1;
    coin_value = 2'd1;
    sel_valid  = 1'b1;
    selection  = 3'd0;
    tick();
    coin_valid = 1'b0;
    sel_valid  = 1'b0;
    check("t2_prio_credit", int'(credit[0]), 15);
    check("t2_prio_no_err", int'(err_insufficient[0]), 0);
    check("t2_prio_no_vend", int'(vend_req[0]), 0);

    // 100+25 refund: dollar (held 3 cycles), then quarter
    do_reset();
    put_coin(2'd3);
    put_coin(2'd2);
    check("t3_credit125", int'(credit[0]), 125);
    refund();
    wait_coin(0, "t3_dollar", seen);
    check("t3_dollar_type", int'(coin_out_type[0]), 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_valid", int'(coin_out_valid[0]), 1);
      check("t3_hold_type", int'(coin_out_type[0]), 3);
    end
    coin_out_ready = 1'b1;
    tick();
    coin_out_ready = 1'b0;
    check("t3_credit25", int'(credit[0]), 25);
    expect_coin(0, 2, "t3_quarter");
    check("t3_credit0", int'(credit[0]), 0);
    check("t3_idle", int'(busy[0]), 0);

    // No quarters in stock: 30 back as three dimes
    do_reset();
    put_coin(2'd1);
    put_coin(2'd1);
    put_coin(2'd1);
    check("t4_credit30", int'(credit[1]), 30);
    refund();
    expect_coin(1, 1, "t4_dime1");
    expect_coin(1, 1, "t4_dime2");
    expect_coin(1, 1, "t4_dime3");
    check("t4_credit0", int'(credit[1]), 0);
    check("t4_idle", int'(busy[1]), 0);

    // No nickels or dimes: change 20 cannot be paid
    do_reset();
    put_coin(2'd2);
    put_coin(2'd2);
    select(3'd1);
    check("t5_vend_req", int'(vend_req[2]), 1);
    check("t5_item_id", int'(item_id[2]), 1);
    ack_vend();
    got_short = 1'b0;
    for (int i = 0; i < 6 && !got_short; i++) begin
      if (change_short[2]) got_short = 1'b1;
      else tick();
    end
    check("t5_change_short", int'(got_short), 1);
    check("t5_credit20", int'(credit[2]), 20);
    check("t5_idle", int'(busy[2]), 0);
    check("t5_no_coin", int'(coin_out_valid[2]), 0);
    tick();
    check("t5_short_pulse", int'(change_short[2]), 0);

    // Overflow reject, reject during VEND, reset during CHANGE
    do_reset();
    put_coin(2'd3);
    put_coin(2'd3);
    put_coin(2'd2);
    put_coin(2'd1);
    put_coin(2'd0);
    check("t6_credit240", int'(credit[0]), 240);
    put_coin(2'd3);
    check("t6_overflow_reject", int'(coin_reject[0]), 1);
    check("t6_credit_kept", int'(credit[0]), 240);
    tick();
    check("t6_reject_pulse", int'(coin_reject[0]), 0);
    select(3'd0);
    check("t6_credit215", int'(credit[0]), 215);
    put_coin(2'd0);
    check("t6_vend_reject", int'(coin_reject[0]), 1);
    check("t6_vend_credit", int'(credit[0]), 215);
    check("t6_vend_req_still", int'(vend_req[0]), 1);
    ack_vend();
    wait_coin(0, "t6_change", seen);
    check("t6_change_type", int'(coin_out_type[0]), 3);
    rst_n = 1'b0;
    tick();
    check("t6_rst_valid", int'(coin_out_valid[0]), 0);
    check("t6_rst_type", int'(coin_out_type[0]), 0);
    check("t6_rst_credit", int'(credit[0]), 0);
    check("t6_rst_busy", int'(busy[0]), 0);
    check("t6_rst_vend_req", int'(vend_req[0]), 0);
    check("t6_rst_item_id", int'(item_id[0]), 0);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Sequencing controller in front of the vending datapath.
- Accumulates inserted coin credit, validates a 3-bit selection against a price, and runs a request/acknowledge handshake with the item dispenser.
- Pays change one coin at a time through a coin-ejector handshake, choosing coins greedily from tracked per-denomination coin inventory.

Parameters:
- BASE_PRICE, 25, price of selection 0 in cents.
- STEP_PRICE, 5, price increment per selection code; price = BASE_PRICE + STEP_PRICE*selection; must be ≤255 for every code.
- NICKEL_INIT, 20, nickel inventory after reset (0..31).
- DIME_INIT, 10, dime inventory after reset (0..31).
- QUARTER_INIT, 8, quarter inventory after reset (0..31).
- DOLLAR_INIT, 4, dollar inventory after reset (0..31).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- coin_valid  in  1  one-cycle pulse: a coin was inserted.
- coin_value  in  2  coin type: 0=5c, 1=10c, 2=25c, 3=100c.
- sel_valid  in  1  one-cycle selection request.
- selection  in  3  item code 0..7.
- refund_req  in  1  one-cycle request to return all credit.
- vend_req  out  1  dispense request to the dispenser.
- item_id  out  3  item to dispense; held stable while vend_req=1.
- vend_ack  in  1  dispenser accepts the request.
- coin_out_valid  out  1  ejector request.
- coin_out_type  out  2  coin to eject, same encoding as coin_value.
- coin_out_ready  in  1  ejector accepts the coin.
- credit  out  8  current credit in cents.
- busy  out  1  high in any state other than IDLE.
- coin_reject  out  1  one-cycle pulse: inserted coin was refused and routed to the mechanical return.
- err_insufficient  out  1  one-cycle pulse: credit was below the selected item's price.
- change_short  out  1  one-cycle pulse: change could not be completed.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - state=IDLE, credit=0.
  - All outputs 0; item_id=0; coin_out_type=0.
  - Inventories reload to their *_INIT values.
  - Reset mid-VEND or mid-CHANGE aborts the operation; vend_req and coin_out_valid are low from the first edge of reset.
- Registers: all state and outputs are registered. A request seen at edge n takes effect at edge n; its result is visible in the following cycle.
- IDLE, evaluated with priority coin > selection > refund:
  - coin_valid:
    - If credit + value ≤ 255: credit += value, and that denomination's inventory increments, saturating at 31.
    - Otherwise: coin_reject pulses and credit is unchanged.
    - sel_valid or refund_req in the same cycle is dropped.
  - sel_valid:
    - If credit ≥ price: credit -= price, item_id latched, go to VEND.
    - Otherwise: err_insufficient pulses; state and credit unchanged.
    - A coinciding refund_req is dropped.
  - refund_req: if credit>0, go to CHANGE; if credit=0, ignored.
- VEND:
  - vend_req=1 and item_id stable until vend_ack=1 at an edge.
  - On that edge: vend_req drops; go to CHANGE if credit>0, else IDLE.
- CHANGE:
  - Coin choice: the largest denomination with value ≤ credit and inventory > 0.
  - Present it as coin_out_valid=1 with coin_out_type.
  - coin_out_type must not change while coin_out_valid=1.
  - On coin_out_ready=1 at an edge: credit -= value and that inventory decrements.
  - Next action after a handshake: if credit=0, go to IDLE with coin_out_valid low; otherwise choose the next coin with at most one idle cycle between coins.
  - If credit>0 and no eligible coin exists: change_short pulses, go to IDLE, and the remaining credit is retained.
- coin_valid in VEND or CHANGE: coin_reject pulses; credit and inventory are unchanged.
- sel_valid and refund_req outside IDLE are ignored.
- vend_ack outside VEND and coin_out_ready while coin_out_valid=0 are ignored.
- Arithmetic: credit is 8-bit unsigned and never wraps; the overflow check uses a 9-bit sum. Inventory counters are 5-bit and saturate at 31 and at 0.

Test Plan:
- Reset, insert 25, 25, 10 (credit 60), select 3 (price 40) → vend_req=1 with item_id=3 the next cycle; vend_ack → coins dime, dime ejected; credit 0; back to IDLE.
- Credit 5, select 6 (price 55) → err_insufficient one cycle; credit stays 5; vend_req stays 0.
- Insert 100, 25, then refund_req → eject dollar then quarter; credit 0; hold coin_out_ready low 3 cycles on the first coin and check coin_out_type stays 3.
- QUARTER_INIT=0: insert 10, 10, 10, then refund → dime, dime, dime (no quarters were inserted, so none are available).
- NICKEL_INIT=0, DIME_INIT=0: insert 25, 25, select 1 (price 30) → vend completes; change 20 cannot be made → change_short pulse, credit=20, IDLE.
- Credit 240, insert 100 → coin_reject, credit 240; coin during VEND → coin_reject; reset asserted during CHANGE → all outputs 0 and credit 0 the next cycle.
